// File: rtl/multi_debounce_pkg.sv
// Shared helpers and types for the multi-channel debouncer.
// Width helpers are evaluated at elaboration time only.
package multi_debounce_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // First long-press pulse, then periodic repeats, or finished for this press.
    typedef enum logic [1:0] {
        HP_FIRST  = 2'd0,
        HP_REPEAT = 2'd1,
        HP_DONE   = 2'd2
    } hold_phase_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: two-flop synchroniser, debounce counter,
// registered press/release pulses and long-press/auto-repeat pulses.
module debounce_channel
    import multi_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 524288,
    parameter int unsigned HOLD_CYCLES     = 0,
    parameter int unsigned REPEAT_CYCLES   = 0,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic released,
    output logic hold
);

    localparam int DEB_W  = clog2(int'(DEBOUNCE_CYCLES));
    localparam int HOLD_W = clog2(max3(int'(HOLD_CYCLES), int'(REPEAT_CYCLES), 2));
    localparam bit HOLD_EN = (HOLD_CYCLES > 0);
    localparam bit REP_EN  = (REPEAT_CYCLES > 0);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(HOLD_EN ? HOLD_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] REP_TGT  = HOLD_W'(REP_EN ? REPEAT_CYCLES - 1 : 0);

    logic [1:0]        sync_q;
    logic              s;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    hold_phase_t       phase_q, phase_d;
    logic              level_d, press_d, released_d, hold_d;

    assign s = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Sync flops park at the inactive raw level so leaving reset is not an edge.
            sync_q     <= {2{ACTIVE_LOW}};
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            phase_q    <= HP_FIRST;
            level      <= 1'b0;
            press      <= 1'b0;
            released   <= 1'b0;
            hold       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q     <= {sync_q[0], raw};
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            phase_q    <= phase_d;
            level      <= level_d;
            press      <= press_d;
            released   <= released_d;
            hold       <= hold_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        deb_cnt_d  = deb_cnt_q + 1'b1;
        level_d    = level;
        press_d    = 1'b0;
        released_d = 1'b0;
        hold_d     = 1'b0;
        hold_cnt_d = hold_cnt_q;
        phase_d    = phase_q;

        if (s == level) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
            deb_cnt_d  = '0;
            level_d    = !level;
            press_d    = !level;
            released_d = level;
        end

        // Hold timing only runs while the level is, and stays, active; a release wins over a hold.
        if (!level || !level_d) begin
            hold_cnt_d = '0;
            phase_d    = HP_FIRST;
        end else if (HOLD_EN && phase_q != HP_DONE) begin
            if (hold_cnt_q == ((phase_q == HP_REPEAT) ? REP_TGT : HOLD_TGT)) begin
                hold_d     = 1'b1;
                hold_cnt_d = '0;
                phase_d    = REP_EN ? HP_REPEAT : HP_DONE;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_debounce.sv
// N-channel debouncer: one independent debounce_channel per input bit,
// outputs concatenated per channel.
module multi_debounce
    import multi_debounce_pkg::*;
#(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 524288,
    parameter int unsigned HOLD_CYCLES     = 0,
    parameter int unsigned REPEAT_CYCLES   = 0,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [N-1:0] Input,
    output logic [N-1:0] State,
    output logic [N-1:0] Press,
    output logic [N-1:0] Release,
    output logic [N-1:0] Hold
);

    for (genvar i = 0; i < int'(N); i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk     (Clk),
            .rst_n   (Rst_n),
            .raw     (Input[i]),
            .level   (State[i]),
            .press   (Press[i]),
            .released(Release[i]),
            .hold    (Hold[i])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: an active-high instance with hold/repeat
// and an active-low instance with hold disabled, sharing clock and reset.
module tb_multi_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_main, state_main, press_main, rel_main, hold_main;
    logic [3:0] in_inv, state_inv, press_inv, rel_inv, hold_inv;

    int total = 0;
    int bad   = 0;
    int inv_events = 0;
    int inv_holds  = 0;

    multi_debounce #(
        .N(4), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(32), .REPEAT_CYCLES(16), .ACTIVE_LOW(1'b0)
    ) dut (
        .Clk(clk), .Rst_n(rst_n), .Input(in_main),
        .State(state_main), .Press(press_main), .Release(rel_main), .Hold(hold_main)
    );

    multi_debounce #(
        .N(4), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(0), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b1)
    ) dut_inv (
        .Clk(clk), .Rst_n(rst_n), .Input(in_inv),
        .State(state_inv), .Press(press_inv), .Release(rel_inv), .Hold(hold_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((|press_inv) || (|rel_inv)) inv_events++;
            if (|hold_inv) inv_holds++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hold_at[4];
        int n_hold;
        int n_ev;

        rst_n   = 1'b0;
        in_main = 4'b0000;
        in_inv  = 4'b1111;
        #12;
        check("rst_state", 32'(state_main), 0);
        check("rst_press", 32'(press_main), 0);
        check("rst_rel",   32'(rel_main),   0);
        check("rst_hold",  32'(hold_main),  0);
        check("rst_inv_state", 32'(state_inv), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(3);

        // Clean press on channel 0: State flips on the 10th edge after the change.
        in_main[0] = 1'b1;
        tick(9);
        check("clean_state_early", 32'(state_main), 0);
        check("clean_press_early", 32'(press_main), 0);
        tick();
        check("clean_state", 32'(state_main), 32'h1);
        check("clean_press", 32'(press_main), 32'h1);
        tick();
        check("clean_press_1cyc", 32'(press_main), 0);
        check("clean_state_hold", 32'(state_main), 32'h1);

        // Bouncing channel 1: high 5 / low 3 four times, then stays high.
        n_ev = 0;
        for (int r = 0; r < 4; r++) begin
            in_main[1] = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (press_main[1] || rel_main[1] || state_main[1]) n_ev++;
            end
            in_main[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (press_main[1] || rel_main[1] || state_main[1]) n_ev++;
            end
        end
        in_main[1] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (press_main[1] || rel_main[1] || state_main[1]) n_ev++;
        end
        check("bounce_quiet", 32'(n_ev), 0);
        tick();
        check("bounce_press", 32'(press_main), 32'h2);
        check("bounce_state", 32'(state_main), 32'h3);

        // Long press on channel 2; released so State falls exactly where the 4th Hold would fire.
        in_main[2] = 1'b1;
        tick(10);
        check("long_press", 32'(press_main), 32'h4);
        for (int i = 0; i < 4; i++) hold_at[i] = -1;
        n_hold = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (hold_main[2]) begin
                if (n_hold < 4) hold_at[n_hold] = c;
                n_hold++;
            end
            if (c == 70) in_main[2] = 1'b0;
            if (c == 79) check("long_rel_early", 32'(rel_main[2]), 0);
            if (c == 80) begin
                check("long_rel", 32'(rel_main), 32'h4);
                check("long_rel_state", 32'(state_main[2]), 0);
                check("long_rel_no_hold", 32'(hold_main[2]), 0);
            end
        end
        check("hold_count", 32'(n_hold), 3);
        check("hold_first",  32'(hold_at[0]), 32);
        check("hold_second", 32'(hold_at[1]), 48);
        check("hold_third",  32'(hold_at[2]), 64);
        n_hold = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (hold_main[2]) n_hold++;
        end
        check("hold_after_rel", 32'(n_hold), 0);

        // Channel 1 released, then channel 0 release coincides with channel 1 press.
        in_main[1] = 1'b0;
        tick(10);
        check("ch1_release", 32'(rel_main), 32'h2);
        in_main[0] = 1'b0;
        in_main[1] = 1'b1;
        tick(9);
        check("simul_early_rel", 32'(rel_main), 0);
        tick();
        check("simul_rel",   32'(rel_main),   32'h1);
        check("simul_press", 32'(press_main), 32'h2);
        check("simul_state", 32'(state_main), 32'h2);
        tick();
        check("simul_rel_1cyc",   32'(rel_main),   0);
        check("simul_press_1cyc", 32'(press_main), 0);

        // Async reset while channel 3 (and channel 1) are pressed.
        in_main[3] = 1'b1;
        tick(10);
        check("rstmid_press", 32'(press_main), 32'h8);
        check("rstmid_state", 32'(state_main), 32'ha);
        tick(3);
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_async_state", 32'(state_main), 0);
        check("rstmid_async_rel",   32'(rel_main),   0);
        check("rstmid_async_press", 32'(press_main), 0);
        tick(2);
        check("rstmid_held_state", 32'(state_main), 0);
        check("rstmid_held_rel",   32'(rel_main),   0);
        rst_n = 1'b1;
        tick(9);
        check("rstmid_relatency_state", 32'(state_main), 0);
        check("rstmid_relatency_rel",   32'(rel_main),   0);
        tick();
        check("rstmid_new_press", 32'(press_main), 32'ha);
        check("rstmid_new_state", 32'(state_main), 32'ha);

        // Active-low instance: idle-high inputs produced nothing so far.
        check("inv_quiet_events", 32'(inv_events), 0);
        check("inv_quiet_state",  32'(state_inv),  0);
        in_inv[0] = 1'b0;
        tick(9);
        check("inv_press_early", 32'(press_inv), 0);
        tick();
        check("inv_press", 32'(press_inv), 32'h1);
        check("inv_state", 32'(state_inv), 32'h1);
        tick(40);
        check("inv_hold_disabled", 32'(inv_holds), 0);
        check("inv_event_count", 32'(inv_events), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
